// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32E core types: opclass enum, opcodes, widths
package core_pkg;

    localparam int CORE_XLEN     = 32;
    localparam int CORE_REGADR_W = 4;

    typedef enum logic [3:0] {
        OPC_LUI     = 4'd0,
        OPC_AUIPC   = 4'd1,
        OPC_JAL     = 4'd2,
        OPC_JALR    = 4'd3,
        OPC_BRANCH  = 4'd4,
        OPC_LOAD    = 4'd5,
        OPC_STORE   = 4'd6,
        OPC_OPIMM   = 4'd7,
        OPC_OP      = 4'd8,
        OPC_FENCE   = 4'd9,
        OPC_SYSTEM  = 4'd10,
        OPC_ILLEGAL = 4'd11
    } opclass_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Every valid opcode ends in 2'b11, so compressed encodings fall to ILLEGAL here.
    function automatic opclass_t opclass_of(input logic [6:0] opcode);
        case (opcode)
            OP_LUI:    opclass_of = OPC_LUI;
            OP_AUIPC:  opclass_of = OPC_AUIPC;
            OP_JAL:    opclass_of = OPC_JAL;
            OP_JALR:   opclass_of = OPC_JALR;
            OP_BRANCH: opclass_of = OPC_BRANCH;
            OP_LOAD:   opclass_of = OPC_LOAD;
            OP_STORE:  opclass_of = OPC_STORE;
            OP_OPIMM:  opclass_of = OPC_OPIMM;
            OP_OP:     opclass_of = OPC_OP;
            OP_FENCE:  opclass_of = OPC_FENCE;
            OP_SYSTEM: opclass_of = OPC_SYSTEM;
            default:   opclass_of = OPC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - format-selected, sign-extended RV32 immediate
module imm_gen
    import core_pkg::*;
(
    input  logic [31:0] instr,
    input  opclass_t    opclass,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (opclass)
            OPC_JALR, OPC_LOAD, OPC_OPIMM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32E decode stage with regfile read-address mux and write bypass
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN     = CORE_XLEN,
    parameter int REGADR_W = CORE_REGADR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic [REGADR_W-1:0] rs1adr,
    output logic [REGADR_W-1:0] rs2adr,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    input  logic                wb_regwrite,
    input  logic [REGADR_W-1:0] wb_rdadr,
    input  logic [XLEN-1:0]     wb_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [3:0]          out_opclass,
    output logic [2:0]          out_funct3,
    output logic                out_funct7b5,
    output logic [REGADR_W-1:0] out_rdadr,
    output logic                out_regwrite,
    output logic [XLEN-1:0]     out_rs1val,
    output logic [XLEN-1:0]     out_rs2val,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_illegal
);

    logic                valid_q, valid_d;
    logic [REGADR_W-1:0] rs1f_q, rs1f_d, rs2f_q, rs2f_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    opclass_t            opclass_q, opclass_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                funct7b5_q, funct7b5_d;
    logic [REGADR_W-1:0] rdadr_q, rdadr_d;
    logic                regwrite_q, regwrite_d;
    logic [XLEN-1:0]     imm_q, imm_d;
    logic                illegal_q, illegal_d;
    logic                byp1_q, byp1_d, byp2_q, byp2_d;
    logic [XLEN-1:0]     bypval1_q, bypval1_d, bypval2_q, bypval2_d;

    logic     accept;
    opclass_t dec_base, dec_class;
    logic     use_rd, use_rs1, use_rs2, writes, reg_bad, dec_regwrite;
    logic [31:0] dec_imm;

    always_comb begin
        dec_base = opclass_of(in_instr[6:0]);
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        writes   = 1'b0;
        case (dec_base)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin use_rd = 1'b1; writes = 1'b1; end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin use_rd = 1'b1; use_rs1 = 1'b1; writes = 1'b1; end
            OPC_OP: begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1; end
            OPC_BRANCH, OPC_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_SYSTEM: begin use_rd = 1'b1; use_rs1 = 1'b1; end
            default: ;
        endcase
        // RV32E has only x0..x15; bit 4 of any used register field is illegal.
        reg_bad      = (use_rd && in_instr[11]) || (use_rs1 && in_instr[19]) || (use_rs2 && in_instr[24]);
        dec_class    = reg_bad ? OPC_ILLEGAL : dec_base;
        dec_regwrite = writes && !reg_bad && (in_instr[11:7] != 5'd0);
    end

    imm_gen u_imm_gen (
        .instr   (in_instr),
        .opclass (dec_class),
        .imm     (dec_imm)
    );

    // Valid-bit FSM (EMPTY/FULL): output process
    always_comb begin
        in_ready  = !flush && (!valid_q || out_ready);
        out_valid = valid_q;
    end

    assign accept = in_valid && in_ready;
    assign rs1adr = accept ? in_instr[15 +: REGADR_W] : rs1f_q;
    assign rs2adr = accept ? in_instr[20 +: REGADR_W] : rs2f_q;

    // Valid-bit FSM: next-state process, plus held-bundle and bypass capture
    always_comb begin
        valid_d    = valid_q;
        rs1f_d     = rs1f_q;
        rs2f_d     = rs2f_q;
        pc_d       = pc_q;
        opclass_d  = opclass_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        rdadr_d    = rdadr_q;
        regwrite_d = regwrite_q;
        imm_d      = imm_q;
        illegal_d  = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            rs1f_d     = in_instr[15 +: REGADR_W];
            rs2f_d     = in_instr[20 +: REGADR_W];
            pc_d       = in_pc;
            opclass_d  = dec_class;
            funct3_d   = in_instr[14:12];
            funct7b5_d = in_instr[30];
            rdadr_d    = in_instr[7 +: REGADR_W];
            regwrite_d = dec_regwrite;
            imm_d      = dec_imm;
            illegal_d  = (dec_class == OPC_ILLEGAL);
        end
        // The regfile returns pre-write data when read and written on the same edge.
        byp1_d    = wb_regwrite && (wb_rdadr != '0) && (wb_rdadr == rs1adr);
        byp2_d    = wb_regwrite && (wb_rdadr != '0) && (wb_rdadr == rs2adr);
        bypval1_d = byp1_d ? wb_rd : bypval1_q;
        bypval2_d = byp2_d ? wb_rd : bypval2_q;
    end

    // Valid-bit FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            rs1f_q     <= '0;
            rs2f_q     <= '0;
            pc_q       <= '0;
            opclass_q  <= OPC_LUI;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            rdadr_q    <= '0;
            regwrite_q <= 1'b0;
            imm_q      <= '0;
            illegal_q  <= 1'b0;
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            bypval1_q  <= '0;
            bypval2_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1f_q     <= rs1f_d;
            rs2f_q     <= rs2f_d;
            pc_q       <= pc_d;
            opclass_q  <= opclass_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            rdadr_q    <= rdadr_d;
            regwrite_q <= regwrite_d;
            imm_q      <= imm_d;
            illegal_q  <= illegal_d;
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            bypval1_q  <= bypval1_d;
            bypval2_q  <= bypval2_d;
        end
    end

    assign out_pc       = pc_q;
    assign out_opclass  = opclass_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign out_rdadr    = rdadr_q;
    assign out_regwrite = regwrite_q;
    assign out_imm      = imm_q;
    assign out_illegal  = illegal_q;
    assign out_rs1val   = byp1_q ? bypval1_q : rs1;
    assign out_rs2val   = byp2_q ? bypval2_q : rs2;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with regfile model
module tb_decode_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush;
    logic [31:0] in_instr, in_pc;
    logic [3:0]  rs1adr, rs2adr, wb_rdadr;
    logic [31:0] rs1, rs2, wb_rd;
    logic        wb_regwrite, out_valid, out_ready;
    logic [31:0] out_pc, out_rs1val, out_rs2val, out_imm;
    logic [3:0]  out_opclass, out_rdadr;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_regwrite, out_illegal;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .rs1adr(rs1adr), .rs2adr(rs2adr), .rs1(rs1), .rs2(rs2),
        .wb_regwrite(wb_regwrite), .wb_rdadr(wb_rdadr), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opclass(out_opclass), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_rdadr(out_rdadr), .out_regwrite(out_regwrite),
        .out_rs1val(out_rs1val), .out_rs2val(out_rs2val),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Register file: registered read, write lands at the same edge (old data read back).
    logic [31:0] rf [16] = '{default: 32'd0};
    always @(posedge clk) begin
        rs1 <= rf[rs1adr];
        rs2 <= rf[rs2adr];
        if (wb_regwrite && wb_rdadr != 4'd0) rf[wb_rdadr] <= wb_rd;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        opclass_t    opc;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  rd;
        logic        rw;
        logic [31:0] imm;
        logic        ill;
        logic [3:0]  a1, a2;
        logic        u1, u2;
    } exp_t;

    exp_t q[$];

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        return v[w-1] ? v - (32'd1 << w) : v;
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [31:0] rd = fld(ins, 11, 7), r1 = fld(ins, 19, 15), r2 = fld(ins, 24, 20);
        logic ud, u1, u2, wr;
        case (fld(ins, 6, 0))
            32'h37: e.opc = OPC_LUI;    32'h17: e.opc = OPC_AUIPC;
            32'h6F: e.opc = OPC_JAL;    32'h67: e.opc = OPC_JALR;
            32'h63: e.opc = OPC_BRANCH; 32'h03: e.opc = OPC_LOAD;
            32'h23: e.opc = OPC_STORE;  32'h13: e.opc = OPC_OPIMM;
            32'h33: e.opc = OPC_OP;     32'h0F: e.opc = OPC_FENCE;
            32'h73: e.opc = OPC_SYSTEM; default: e.opc = OPC_ILLEGAL;
        endcase
        wr = e.opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP};
        ud = wr || e.opc == OPC_SYSTEM;
        u1 = e.opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM};
        u2 = e.opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        if ((ud && rd > 15) || (u1 && r1 > 15) || (u2 && r2 > 15)) e.opc = OPC_ILLEGAL;
        e.ill = (e.opc == OPC_ILLEGAL);
        e.rw  = !e.ill && wr && rd != 0;
        e.u1  = !e.ill && u1;
        e.u2  = !e.ill && u2;
        e.a1  = r1[3:0];
        e.a2  = r2[3:0];
        e.pc  = pc;
        e.f3  = fld(ins, 14, 12);
        e.f7  = ins[30];
        e.rd  = rd[3:0];
        case (e.opc)
            OPC_JALR, OPC_LOAD, OPC_OPIMM: e.imm = sext(fld(ins, 31, 20), 12);
            OPC_STORE:  e.imm = sext((fld(ins, 31, 25) << 5) | fld(ins, 11, 7), 12);
            OPC_BRANCH: e.imm = sext((fld(ins, 31, 31) << 12) | (fld(ins, 7, 7) << 11)
                                   | (fld(ins, 30, 25) << 5) | (fld(ins, 11, 8) << 1), 13);
            OPC_LUI, OPC_AUIPC: e.imm = ins & 32'hFFFFF000;
            OPC_JAL:    e.imm = sext((fld(ins, 31, 31) << 20) | (fld(ins, 19, 12) << 12)
                                   | (fld(ins, 20, 20) << 11) | (fld(ins, 30, 21) << 1), 21);
            default:    e.imm = 32'd0;
        endcase
        return e;
    endfunction

    // Monitor: check held bundle every valid cycle, retire on handshake or flush.
    exp_t m_e;
    logic m_v, m_ir;
    always @(negedge clk) begin
        m_v  = (q.size() != 0);
        m_ir = !flush && (!m_v || out_ready);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_v});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
        if (m_v && out_valid) begin
            m_e = q[0];
            chk("pc", out_pc, m_e.pc);
            chk("opclass", 32'(out_opclass), 32'(m_e.opc));
            chk("funct3", 32'(out_funct3), 32'(m_e.f3));
            chk("funct7b5", 32'(out_funct7b5), 32'(m_e.f7));
            chk("rdadr", 32'(out_rdadr), 32'(m_e.rd));
            chk("regwrite", 32'(out_regwrite), 32'(m_e.rw));
            chk("illegal", 32'(out_illegal), 32'(m_e.ill));
            chk("imm", out_imm, m_e.imm);
            if (m_e.u1) chk("rs1val", out_rs1val, rf[m_e.a1]);
            if (m_e.u2) chk("rs2val", out_rs2val, rf[m_e.a2]);
        end
        if (!reset) begin
            q.delete();
        end else begin
            if (m_v && (flush || out_ready)) void'(q.pop_front());
            if (in_valid && m_ir) q.push_back(ref_dec(in_instr, in_pc));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] pcv = 32'h0000_1000;
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pcv;
        pcv      = pcv + 4;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins = $urandom;
        int k = $urandom_range(0, 11);
        ins[6:0] = (k == 11) ? 7'($urandom) : ops[k];
        if ($urandom_range(0, 7) != 0) ins[11] = 1'b0;
        if ($urandom_range(0, 7) != 0) ins[19] = 1'b0;
        if ($urandom_range(0, 7) != 0) ins[24] = 1'b0;
        return ins;
    endfunction

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_regwrite = 1'b0; wb_rdadr = '0; wb_rd = '0; out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst opclass", 32'(out_opclass), 32'd0);
        chk("rst imm", out_imm, 32'd0);
        chk("rst illegal", 32'(out_illegal), 32'd0);
        chk("rst regwrite", 32'(out_regwrite), 32'd0);
        chk("rst rdadr", 32'(out_rdadr), 32'd0);
        tick();
        reset = 1'b1;
        wb_regwrite = 1'b1; wb_rdadr = 4'd1; wb_rd = 32'd10; tick();
        wb_rdadr = 4'd2; wb_rd = 32'd32; tick();
        wb_regwrite = 1'b0;
        out_ready = 1'b1;

        issue(32'h00700293);
        @(negedge clk);
        chk("addi opclass", 32'(out_opclass), 32'(OPC_OPIMM));
        chk("addi rdadr", 32'(out_rdadr), 32'd5);
        chk("addi imm", out_imm, 32'd7);
        chk("addi rs1val", out_rs1val, 32'd0);
        chk("addi regwrite", 32'(out_regwrite), 32'd1);
        tick();

        issue(32'h002081B3);
        @(negedge clk);
        chk("add rs1val", out_rs1val, 32'd10);
        chk("add rs2val", out_rs2val, 32'd32);
        chk("add funct7b5", 32'(out_funct7b5), 32'd0);
        chk("add rdadr", 32'(out_rdadr), 32'd3);
        tick();

        wb_regwrite = 1'b1; wb_rdadr = 4'd1; wb_rd = 32'hDEADBEEF;
        issue(32'h002081B3);
        wb_regwrite = 1'b0;
        @(negedge clk);
        chk("bypass rs1val", out_rs1val, 32'hDEADBEEF);
        tick();

        wb_regwrite = 1'b1; wb_rdadr = 4'd0; wb_rd = 32'hDEADBEEF;
        issue(32'h002001B3);
        wb_regwrite = 1'b0;
        @(negedge clk);
        chk("x0 no bypass", out_rs1val, 32'd0);
        tick();

        out_ready = 1'b0;
        issue(32'h002081B3);
        tick();
        wb_regwrite = 1'b1; wb_rdadr = 4'd2; wb_rd = 32'h55;
        tick();
        wb_regwrite = 1'b0;
        @(negedge clk);
        chk("stall rs2val", out_rs2val, 32'h55);
        chk("stall in_ready", 32'(in_ready), 32'd0);
        chk("stall rdadr", 32'(out_rdadr), 32'd3);
        tick();
        out_ready = 1'b1;
        tick();

        issue(32'h002088B3);
        @(negedge clk);
        chk("x17 illegal", 32'(out_illegal), 32'd1);
        chk("x17 opclass", 32'(out_opclass), 32'(OPC_ILLEGAL));
        chk("x17 regwrite", 32'(out_regwrite), 32'd0);
        tick();
        issue(32'h123450B7);
        @(negedge clk);
        chk("lui imm", out_imm, 32'h12345000);
        tick();

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = rnd_instr(); in_pc = pcv; pcv = pcv + 4;
            tick();
        end
        in_valid = 1'b0;
        tick();

        out_ready = 1'b0;
        issue(32'h00700293);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3;
        @(negedge clk);
        chk("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        tick();

        issue(32'h00700293);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("stall reset out_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_instr    = rnd_instr();
            in_pc       = $urandom & 32'hFFFF_FFFC;
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_regwrite = $urandom_range(0, 1) == 1;
            wb_rdadr    = 4'($urandom_range(0, 15));
            wb_rd       = $urandom;
            reset       = ($urandom_range(0, 199) != 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b1; out_ready = 1'b1; wb_regwrite = 1'b0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage of the RV32E core; sits between fetch and execute, directly upstream of the 16-entry register file (`regs`).
- Accepts one instruction per valid/ready handshake and drives register-file read addresses combinationally in the accept cycle.
- One cycle later, presents the decoded bundle, operands and immediate to execute over a second valid/ready handshake.
- Corrects the register file's same-edge write/read hazard with a one-entry bypass per operand.

Parameters:
- XLEN, 32, datapath width.
- REGADR_W, 4, register address width (RV32E, 16 registers).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  decode can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  squash held instruction (branch/trap redirect)
- rs1adr  out  REGADR_W  to regs
- rs2adr  out  REGADR_W  to regs
- rs1  in  XLEN  registered read data from regs
- rs2  in  XLEN  registered read data from regs
- wb_regwrite  in  1  writeback write enable (same signal as regs.regwrite)
- wb_rdadr  in  REGADR_W  writeback address
- wb_rd  in  XLEN  writeback data
- out_valid  out  1  bundle valid to execute
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC of held instruction
- out_opclass  out  4  opclass_t (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILLEGAL)
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_rdadr  out  REGADR_W  destination
- out_regwrite  out  1  instruction writes rd (and rd != 0)
- out_rs1val  out  XLEN  operand 1
- out_rs2val  out  XLEN  operand 2
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  illegal instruction flag

Behaviour:
- Reset (reset==0 at posedge): out_valid=0; held instr, PC and all out_* fields = 0; bypass flags = 0. Reset overrides accept and flush.
- Handshake: in_ready = !flush && (!out_valid || out_ready). Accept = in_valid && in_ready. On accept, latch instr/PC; out_valid=1 next cycle.
- Latency: 1 cycle from accept to out_valid. Sustained throughput 1/cycle when out_ready is held high.
- out_valid && out_ready && !accept -> out_valid=0. The held bundle is stable while out_valid && !out_ready.
- Address mux: rs1adr/rs2adr = in_instr[18:15]/[23:20] when accept, else held instr fields. regs samples these at the same edge as the accept.
- Bypass, evaluated every cycle per operand: if wb_regwrite && wb_rdadr != 0 && wb_rdadr == rsNadr (current mux value), set bypN <= 1 and bypvalN <= wb_rd; else bypN <= 0.
- out_rsNval = bypN ? bypvalN : rsN. This also covers writes landing while stalled.
- Address x0 is never bypassed.
- Zero-source classes (LUI, AUIPC, JAL): operand values are don't-care; bench checks only for classes that use them.
- Decode: opclass from instr[6:0]. Unknown opcode or instr[1:0] != 2'b11 -> ILLEGAL.
- Any used register field with bit 4 set (x16..x31) -> out_illegal=1 and opclass ILLEGAL.
- out_illegal=1 implies out_regwrite=0.
- out_regwrite = 1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP when rd != 0.
- Immediates follow standard RV formats I/S/B/U/J, sign-extended from instr[31]. Zero for OP, FENCE, SYSTEM.
- Flush: at the next edge out_valid=0; no accept that cycle. Flush and out_ready in the same cycle -> flush wins; the consumer must not treat it as a handshake.

Decomposition:
- Package `core_pkg`: opclass_t enum, opcode localparams, XLEN/REGADR_W constants.
- Sub-module `imm_gen`: combinational instr -> format-selected immediate, shared later with any compressed/alternate decode.
- FSM is implicit: a single valid bit (EMPTY/FULL).

Test Plan:
- Reset sequence, then in_instr=0x00700293 (addi x5,x0,7) accepted -> next cycle out_valid=1, opclass OPIMM, rdadr=5, imm=7, rs1val=0, regwrite=1.
- Preload x1=10, x2=32; 0x002081B3 (add x3,x1,x2) -> rs1val=10, rs2val=32, funct7b5=0, rdadr=3.
- Accept add x3,x1,x2 in the same cycle as wb write x1=0xDEADBEEF -> out_rs1val=0xDEADBEEF. Same test with wb_rdadr=0 -> no bypass, value 0.
- out_ready=0 for 3 cycles while wb writes x2=0x55 in stall cycle 2 -> bundle stable; rs2val=0x55 from the cycle after the write. in_ready=0 throughout the stall.
- 0x002088B3 (rd=x17) -> out_illegal=1, opclass ILLEGAL, regwrite=0. 0x123450B7 (lui x1) -> imm=0x12345000.
- Back-to-back stream with out_ready=1 -> one bundle per cycle. Flush asserted with out_valid=1 -> out_valid=0 next cycle, in_ready=0 during the flush cycle. Reset asserted mid-stall -> out_valid=0.
